// File: rtl/core_seq_ctrl_pkg.sv
// rtl/core_seq_ctrl_pkg.sv - sequencer states, RV32I opcodes and halt codes
package core_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH_REQ  = 3'd0,
    ST_FETCH_WAIT = 3'd1,
    ST_EXEC       = 3'd2,
    ST_MEM_REQ    = 3'd3,
    ST_MEM_WAIT   = 3'd4,
    ST_WB         = 3'd5,
    ST_HALT       = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ERR_EBREAK  = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  function automatic logic is_mem_op(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

  // Legal non-memory instructions that retire straight through WB.
  function automatic logic is_wb_op(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LUI) ||
           (opc == OPC_AUIPC) || (opc == OPC_JAL) || (opc == OPC_JALR) ||
           (opc == OPC_BRANCH);
  endfunction

  function automatic logic writes_rd(input logic [6:0] opc);
    return (opc != OPC_STORE) && (opc != OPC_BRANCH);
  endfunction

endpackage

// File: rtl/core_seq_ctrl_bus_watchdog.sv
// rtl/core_seq_ctrl_bus_watchdog.sv - per-state bus wait cycle limiter
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Asserts during the TIMEOUT-th consecutive cycle spent in one wait state.
  assign expired = run && (cnt == LAST);

endmodule

// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - multi-cycle fetch/exec/mem/writeback sequencer
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  output logic [31:0]      ifu_req_addr,
  input  logic             ifu_rsp_valid,
  input  logic [31:0]      ifu_rsp_data,
  output logic             lsu_req_valid,
  output logic             lsu_req_we,
  input  logic             lsu_req_ready,
  input  logic             lsu_rsp_valid,
  input  logic [31:0]      next_pc,
  output logic [31:0]      pc,
  output logic [31:0]      inst,
  output logic             rf_wen,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             halted,
  output logic [1:0]       err_code
);

  state_t           state, state_nx;
  err_t             err_q, err_nx;
  logic [31:0]      pc_q, inst_q;
  logic [CNT_W-1:0] retire_q;
  logic [6:0]       opc;
  logic             wd_clear, wd_run, wd_expired;

  assign opc = inst_q[6:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_FETCH_REQ;
      err_q    <= ERR_EBREAK;
      pc_q     <= RESET_PC;
      inst_q   <= '0;
      retire_q <= '0;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
      if ((state == ST_FETCH_WAIT) && ifu_rsp_valid) begin
        inst_q <= ifu_rsp_data;
      end
      if (state == ST_WB) begin
        pc_q     <= next_pc;
        retire_q <= retire_q + CNT_W'(1);
      end
    end
  end

  // Each wait state checks its handshake first so a late exit beats the watchdog.
  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    case (state)
      ST_FETCH_REQ: begin
        if (ifu_req_ready) begin
          state_nx = ST_FETCH_WAIT;
        end else if (wd_expired) begin
          state_nx = ST_HALT;
          err_nx   = ERR_TIMEOUT;
        end
      end
      ST_FETCH_WAIT: begin
        if (ifu_rsp_valid) begin
          state_nx = ST_EXEC;
        end else if (wd_expired) begin
          state_nx = ST_HALT;
          err_nx   = ERR_TIMEOUT;
        end
      end
      ST_EXEC: begin
        if (is_mem_op(opc)) begin
          state_nx = ST_MEM_REQ;
        end else if (inst_q == INST_EBREAK) begin
          state_nx = ST_HALT;
          err_nx   = ERR_EBREAK;
        end else if (is_wb_op(opc)) begin
          state_nx = ST_WB;
        end else begin
          state_nx = ST_HALT;
          err_nx   = ERR_ILLEGAL;
        end
      end
      ST_MEM_REQ: begin
        if (lsu_req_ready) begin
          state_nx = ST_MEM_WAIT;
        end else if (wd_expired) begin
          state_nx = ST_HALT;
          err_nx   = ERR_TIMEOUT;
        end
      end
      ST_MEM_WAIT: begin
        if (lsu_rsp_valid) begin
          state_nx = ST_WB;
        end else if (wd_expired) begin
          state_nx = ST_HALT;
          err_nx   = ERR_TIMEOUT;
        end
      end
      ST_WB:   state_nx = ST_FETCH_REQ;
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_FETCH_REQ;
    endcase
  end

  assign wd_run = (state == ST_FETCH_REQ) || (state == ST_FETCH_WAIT) ||
                  (state == ST_MEM_REQ) || (state == ST_MEM_WAIT);
  assign wd_clear = (state_nx != state);

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .run     (wd_run),
    .expired (wd_expired)
  );

  // Reset forces FETCH_REQ, so strobes are gated by rst_n to stay quiet during reset.
  assign ifu_req_valid = rst_n && (state == ST_FETCH_REQ);
  assign ifu_req_addr  = pc_q;
  assign lsu_req_valid = rst_n && (state == ST_MEM_REQ);
  assign lsu_req_we    = lsu_req_valid && (opc == OPC_STORE);
  assign rf_wen        = rst_n && (state == ST_WB) && writes_rd(opc) && (inst_q[11:7] != 5'd0);
  assign pc            = pc_q;
  assign inst          = inst_q;
  assign retire_cnt    = retire_q;
  assign halted        = (state == ST_HALT);
  assign err_code      = err_q;

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the single-issue NPC datapath (ALU + RegisterFile + LSU).
- Owns the PC, the instruction fetch handshake and the data-memory handshake, and gates the register-file write enable so that exactly one writeback occurs per retired instruction.
- Datapath computes next_pc and results; this block decides when they are consumed.
- Also halts on ebreak, illegal opcode or bus timeout, and counts retired instructions.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
TIMEOUT, 255, maximum cycles in any single bus-wait state before error halt (valid range 1..255).
CNT_W, 64, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
ifu_req_valid  out  1  fetch request valid.
ifu_req_ready  in  1  fetch request accepted.
ifu_req_addr  out  32  fetch address (= pc).
ifu_rsp_valid  in  1  fetch data valid.
ifu_rsp_data  in  32  fetched instruction.
lsu_req_valid  out  1  data request valid.
lsu_req_we  out  1  1 = store, 0 = load.
lsu_req_ready  in  1  data request accepted.
lsu_rsp_valid  in  1  load data or store acknowledge.
next_pc  in  32  datapath-computed successor PC (branch/jump resolved).
pc  out  32  current PC.
inst  out  32  latched instruction, stable from EXEC through WB.
rf_wen  out  1  register-file write enable.
retire_cnt  out  CNT_W  retired instructions.
halted  out  1  core stopped.
err_code  out  2  00 ebreak, 01 illegal, 10 bus timeout; valid only when halted.

Behaviour:
- Reset (async assert, sync-released by flops on the next clk edge) sets the following state:
  - state = FETCH_REQ; pc = RESET_PC; inst = 0; retire_cnt = 0; halted = 0; err_code = 00.
  - While rst_n = 0, all request valids and rf_wen are 0.
  - Reset asserted mid-transaction abandons the transaction; responses arriving after release are ignored unless the FSM is in the matching WAIT state.
- All outputs are Moore outputs decoded from registered state.
- States:
  - FETCH_REQ: ifu_req_valid = 1, addr = pc. ifu_req_ready = 1 → FETCH_WAIT. Valid and addr are held until ready.
  - FETCH_WAIT: ifu_rsp_valid = 1 → latch ifu_rsp_data into inst, go to EXEC. A response seen in FETCH_REQ is ignored.
  - EXEC: one cycle; decode inst[6:0].
    - LOAD (0000011) or STORE (0100011) → MEM_REQ.
    - inst == 32'h0010_0073 → HALT, err 00.
    - OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH → WB.
    - Anything else → HALT, err 01.
  - MEM_REQ: lsu_req_valid = 1; lsu_req_we = 1 for STORE. lsu_req_ready = 1 → MEM_WAIT.
  - MEM_WAIT: lsu_rsp_valid = 1 → WB.
  - WB: one cycle.
    - rf_wen = 1 iff the opcode writes rd (not STORE/BRANCH) and inst[11:7] != 0.
    - pc <= next_pc; retire_cnt += 1 (wraps modulo 2^CNT_W); go to FETCH_REQ.
  - HALT: terminal until reset. All valids and rf_wen are 0, halted = 1. pc and inst are frozen; the ebreak/illegal instruction is not retired.
- Watchdog:
  - Counter clears on entry to FETCH_REQ, FETCH_WAIT, MEM_REQ or MEM_WAIT, and increments each cycle in those states.
  - When the count reaches TIMEOUT without the exit condition → HALT, err 10.
  - If the exit condition and count == TIMEOUT occur in the same cycle, the exit condition wins.
- Zero-wait latency (ready = 1 always, rsp the cycle after accept):
  - ALU op: 4 cycles per instruction.
  - load/store: 6 cycles per instruction.
- pc is only updated in WB; a misaligned next_pc is passed through unchecked.

Decomposition:
- Shared header/package, reused by the decoder and the trace bench:
  - state encoding localparams (FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT);
  - RV32I opcode constants;
  - EBREAK encoding;
  - err_code values.
- One sub-module: bus_watchdog (clk, rst_n, clear, run, expired; TIMEOUT parameter).

Test Plan:
- After reset release, with ready = 1 and ifu_rsp returning 0x00500093 (addi x1, x0, 5) one cycle after accept and next_pc = pc + 4:
  - ifu_req_addr = 0x80000000;
  - rf_wen high for exactly 1 cycle, 4 cycles after the request;
  - then pc = 0x80000004, retire_cnt = 1.
- Load 0x00002103 with lsu_req_ready held low for 3 cycles:
  - lsu_req_valid stays high those 3 cycles;
  - WB follows the cycle after lsu_rsp_valid;
  - rf_wen = 1, retire_cnt increments.
- Store 0x00112023 → lsu_req_we = 1, rf_wen stays 0 through WB, pc advances.
- addi x0, x0, 1 (0x00100013) → rf_wen stays 0, retire_cnt still increments.
- ebreak 0x00100073 → halted = 1 and err_code = 00 two cycles after fetch response; retire_cnt unchanged, no further ifu_req_valid.
- Invalid opcode 0xFFFFFFFF → halted with err 01.
- ifu_rsp_valid never asserted → halted with err 10 exactly TIMEOUT cycles after FETCH_WAIT entry.
- Reset pulsed while in MEM_WAIT → pc back to 0x80000000, retire_cnt = 0, fresh fetch issued after release.
